// File: rtl/pixel_stream_proc_if.sv
// Bus bundle for pixel_stream_proc: job control, source RAM read port and
// destination RAM write port.
interface pixel_stream_proc_if #(
  parameter int ADDR_BITS = 10,
  parameter int CH_BITS   = 8,
  parameter int CHANNELS  = 3
);
  localparam int P = CH_BITS * CHANNELS;

  logic                 start;
  logic [1:0]           mode;
  logic [CH_BITS-1:0]   thresh;
  logic [ADDR_BITS-1:0] base;
  logic [ADDR_BITS:0]   count;
  logic [ADDR_BITS-1:0] src_addr;
  logic [P-1:0]         src_data;
  logic [ADDR_BITS-1:0] dst_addr;
  logic [P-1:0]         dst_data;
  logic                 dst_we;
  logic                 busy;
  logic                 done;
  logic [ADDR_BITS:0]   processed;

  modport master (
    output start, mode, thresh, base, count, src_data,
    input  src_addr, dst_addr, dst_data, dst_we, busy, done, processed
  );

  modport slave (
    input  start, mode, thresh, base, count, src_data,
    output src_addr, dst_addr, dst_data, dst_we, busy, done, processed
  );
endinterface

// File: rtl/pixel_stream_proc.sv
// Per-pixel stream processor: reads count pixels from a source RAM starting at
// base, applies copy/grey/invert/threshold, and writes them to a destination RAM.
module pixel_stream_proc #(
  parameter int ADDR_BITS = 10,
  parameter int CH_BITS   = 8,
  parameter int CHANNELS  = 3
) (
  input logic               clk,
  input logic               reset,
  pixel_stream_proc_if.slave bus
);
  localparam int P = CH_BITS * CHANNELS;

  typedef enum logic [2:0] {IDLE, READ, APPLY, WRITE, NEXT, FIN} state_t;

  state_t               state;
  logic [1:0]           mode_r;
  logic [CH_BITS-1:0]   thresh_r;
  logic [ADDR_BITS-1:0] base_r;
  logic [ADDR_BITS:0]   count_r;
  logic [ADDR_BITS:0]   index;
  logic [ADDR_BITS:0]   index_nxt;
  logic [P-1:0]         result;

  assign index_nxt    = index + 1'b1;
  assign bus.dst_data = result;

  // Missing channels (CHANNELS<3) shift in as zero, so they read as 0.
  function automatic logic [P-1:0] apply_op(input logic [1:0]         op,
                                            input logic [CH_BITS-1:0] th,
                                            input logic [P-1:0]       pix);
    logic [CH_BITS-1:0] c0, c1, c2, y;
    logic [CH_BITS+1:0] sum;
    logic [P-1:0]       res;
    c0  = CH_BITS'(pix);
    c1  = CH_BITS'(pix >> CH_BITS);
    c2  = CH_BITS'(pix >> (2 * CH_BITS));
    sum = {2'b00, c0} + {1'b0, c1, 1'b0} + {2'b00, c2};
    y   = sum[CH_BITS+1:2];
    res = '0;
    case (op)
      2'd0: res = pix;
      2'd1: for (int unsigned ch = 0; ch < CHANNELS; ch++) res[ch*CH_BITS +: CH_BITS] = y;
      2'd2: res = ~pix;
      default: res = (y >= th) ? '1 : '0;
    endcase
    return res;
  endfunction

  // src_addr is loaded on the edge entering READ so it is valid throughout READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mode_r        <= '0;
      thresh_r      <= '0;
      base_r        <= '0;
      count_r       <= '0;
      index         <= '0;
      result        <= '0;
      bus.src_addr  <= '0;
      bus.dst_addr  <= '0;
      bus.dst_we    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.processed <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_r        <= bus.mode;
            thresh_r      <= bus.thresh;
            base_r        <= bus.base;
            count_r       <= bus.count;
            index         <= '0;
            bus.processed <= '0;
            bus.src_addr  <= bus.base;
            bus.busy      <= 1'b1;
            if (bus.count == '0) begin
              bus.done <= 1'b1;
              state    <= FIN;
            end else begin
              state <= READ;
            end
          end
        end
        READ: state <= APPLY;
        APPLY: begin
          result       <= apply_op(mode_r, thresh_r, bus.src_data);
          bus.dst_addr <= bus.src_addr;
          bus.dst_we   <= 1'b1;
          state        <= WRITE;
        end
        WRITE: begin
          bus.dst_we <= 1'b0;
          state      <= NEXT;
        end
        NEXT: begin
          index         <= index_nxt;
          bus.processed <= bus.processed + 1'b1;
          if (index_nxt < count_r) begin
            bus.src_addr <= base_r + index_nxt[ADDR_BITS-1:0];
            state        <= READ;
          end else begin
            bus.done <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
